// File: rtl/mem_access_stage.sv
// Memory-stage controller for ARM single-data-transfer loads/stores.
// Computes the indexed address, runs a req/ack memory transaction, returns load and base writeback.
//
// state  | meaning
// IDLE   | waiting for a load/store in the EX register; captures it on acceptance
// ACCESS | dm_req asserted, all dm_* held stable until dm_ack is sampled
// RESP   | one-cycle wb_valid / base_wb_valid pulse, then back to IDLE

module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid_in,
    input  logic        load_store,
    input  logic        byte_word,
    input  logic        pre_post,
    input  logic        up_down,
    input  logic        write_back,
    input  logic [31:0] base_data,
    input  logic [31:0] offset_data,
    input  logic [31:0] store_data,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        base_wb_valid,
    output logic [3:0]  base_wb_rn,
    output logic [31:0] base_wb_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        load_q;
    logic        byte_q;
    logic        base_wb_q;
    logic [1:0]  lane_q;

    logic [31:0] eff;
    logic [31:0] addr;
    logic [7:0]  rdata_lane;

    assign eff  = up_down ? (base_data + offset_data) : (base_data - offset_data);
    assign addr = pre_post ? eff : base_data;

    always_comb begin
        rdata_lane = dm_rdata[7:0];
        case (lane_q)
            2'd0: rdata_lane = dm_rdata[7:0];
            2'd1: rdata_lane = dm_rdata[15:8];
            2'd2: rdata_lane = dm_rdata[23:16];
            2'd3: rdata_lane = dm_rdata[31:24];
            default: rdata_lane = dm_rdata[7:0];
        endcase
    end

    // Gated by reset so upstream is never held while the stage is being reset.
    assign stall = reset && (((state == IDLE) && mem_valid_in) || (state == ACCESS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            load_q        <= 1'b0;
            byte_q        <= 1'b0;
            base_wb_q     <= 1'b0;
            lane_q        <= 2'd0;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= 32'd0;
            dm_wdata      <= 32'd0;
            dm_be         <= 4'd0;
            wb_valid      <= 1'b0;
            wb_rd         <= 4'd0;
            wb_data       <= 32'd0;
            base_wb_valid <= 1'b0;
            base_wb_rn    <= 4'd0;
            base_wb_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid      <= 1'b0;
                    base_wb_valid <= 1'b0;
                    if (mem_valid_in) begin
                        state        <= ACCESS;
                        load_q       <= load_store;
                        byte_q       <= byte_word;
                        lane_q       <= addr[1:0];
                        // A load into the base register wins over the base update.
                        base_wb_q    <= (write_back || !pre_post) && !(load_store && (rd == rn));
                        dm_req       <= 1'b1;
                        dm_we        <= !load_store;
                        dm_addr      <= {addr[31:2], 2'b00};
                        dm_wdata     <= byte_word ? {4{store_data[7:0]}} : store_data;
                        dm_be        <= byte_word ? (4'b0001 << addr[1:0]) : 4'hF;
                        wb_rd        <= rd;
                        base_wb_rn   <= rn;
                        base_wb_data <= eff;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        state         <= RESP;
                        dm_req        <= 1'b0;
                        dm_we         <= 1'b0;
                        wb_data       <= byte_q ? {24'd0, rdata_lane} : dm_rdata;
                        wb_valid      <= load_q;
                        base_wb_valid <= base_wb_q;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    wb_valid      <= 1'b0;
                    base_wb_valid <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    dm_req        <= 1'b0;
                    dm_we         <= 1'b0;
                    wb_valid      <= 1'b0;
                    base_wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected writebacks are queued at issue time
// and popped when the RESP pulse appears.

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid_in, load_store, byte_word, pre_post, up_down, write_back;
    logic [31:0] base_data, offset_data, store_data;
    logic [3:0]  rd, rn;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        wb_valid, base_wb_valid;
    logic [3:0]  wb_rd, base_wb_rn;
    logic [31:0] wb_data, base_wb_data;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    typedef struct {
        logic        wv;
        logic [3:0]  wrd;
        logic [31:0] wd;
        logic        bv;
        logic [3:0]  brn;
        logic [31:0] bd;
    } resp_t;

    resp_t sb[$];

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .reset(reset), .mem_valid_in(mem_valid_in), .load_store(load_store),
        .byte_word(byte_word), .pre_post(pre_post), .up_down(up_down), .write_back(write_back),
        .base_data(base_data), .offset_data(offset_data), .store_data(store_data),
        .rd(rd), .rn(rn), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata),
        .dm_ack(dm_ack), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .base_wb_valid(base_wb_valid), .base_wb_rn(base_wb_rn), .base_wb_data(base_wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic ls, input logic bw, input logic pp, input logic ud,
                          input logic wbk, input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] sd, input logic [3:0] r_d, input logic [3:0] r_n,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input resp_t exp);
        resp_t got;
        int    stall_cycles;
        @(negedge clk);
        chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("idle_base_wb_valid", {31'd0, base_wb_valid}, 32'd0);
        mem_valid_in = 1'b1; load_store = ls; byte_word = bw; pre_post = pp; up_down = ud;
        write_back = wbk; base_data = base; offset_data = off; store_data = sd; rd = r_d; rn = r_n;
        #1;
        chk("accept_stall", {31'd0, stall}, 32'd1);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        mem_valid_in = 1'b0;
        base_data = 32'h0; offset_data = 32'h0; store_data = 32'h0;
        stall_cycles = 0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            chk("access_req", {31'd0, dm_req}, 32'd1);
            chk("access_we", {31'd0, dm_we}, {31'd0, ~ls});
            chk("access_addr", dm_addr, exp_addr);
            chk("access_be", {28'd0, dm_be}, {28'd0, exp_be});
            if (!ls) chk("access_wdata", dm_wdata, exp_wdata);
            dm_rdata = (i == waits) ? rdata : 32'hBADBAD00;
            dm_ack = (i == waits);
            @(posedge clk);
        end
        #1;
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        chk("stall_cycles", stall_cycles, waits + 1);
        @(negedge clk);
        chk("resp_stall", {31'd0, stall}, 32'd0);
        chk("resp_req", {31'd0, dm_req}, 32'd0);
        chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, got.wv});
            if (got.wv) begin
                chk("wb_rd", {28'd0, wb_rd}, {28'd0, got.wrd});
                chk("wb_data", wb_data, got.wd);
            end
            chk("base_wb_valid", {31'd0, base_wb_valid}, {31'd0, got.bv});
            if (got.bv) begin
                chk("base_wb_rn", {28'd0, base_wb_rn}, {28'd0, got.brn});
                chk("base_wb_data", base_wb_data, got.bd);
            end
        end
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b0;
        mem_valid_in = 1'b1; load_store = 1'b0; byte_word = 1'b0; pre_post = 1'b0;
        up_down = 1'b0; write_back = 1'b0; base_data = 32'h0; offset_data = 32'h0;
        store_data = 32'h0; rd = 4'd0; rn = 4'd0; dm_rdata = 32'h0; dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_base_wb_data", base_wb_data, 32'd0);
        mem_valid_in = 1'b0;
        reset = 1'b1;

        // Stray ack while idle must not start or complete anything.
        dm_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack_req", {31'd0, dm_req}, 32'd0);
            chk("idle_ack_wb", {31'd0, wb_valid | base_wb_valid}, 32'd0);
        end
        dm_ack = 1'b0;

        run_op(1, 0, 1, 1, 1, 32'h1000, 32'h8, 32'h0, 4'd2, 4'd3, 0, 32'hDEADBEEF,
               32'h1008, 4'hF, 32'h0, '{1'b1, 4'd2, 32'hDEADBEEF, 1'b1, 4'd3, 32'h1008});
        run_op(0, 1, 0, 0, 0, 32'h2003, 32'h4, 32'h000000A5, 4'd1, 4'd4, 0, 32'h0,
               32'h2000, 4'b1000, 32'hA5A5A5A5, '{1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h1FFF});
        run_op(1, 1, 1, 1, 0, 32'h3002, 32'h0, 32'h0, 4'd7, 4'd8, 3, 32'h11CC2233,
               32'h3000, 4'b0100, 32'h0, '{1'b1, 4'd7, 32'h000000CC, 1'b0, 4'd0, 32'h0});
        run_op(0, 0, 1, 1, 0, 32'hFFFFFFFC, 32'h8, 32'h12345678, 4'd1, 4'd2, 1, 32'h0,
               32'h4, 4'hF, 32'h12345678, '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0});
        run_op(1, 0, 1, 1, 1, 32'h4000, 32'h10, 32'h0, 4'd5, 4'd5, 0, 32'hCAFEF00D,
               32'h4010, 4'hF, 32'h0, '{1'b1, 4'd5, 32'hCAFEF00D, 1'b0, 4'd0, 32'h0});
        run_op(1, 1, 0, 0, 0, 32'h5007, 32'h3, 32'h0, 4'd6, 4'd9, 2, 32'hAB000000,
               32'h5004, 4'b1000, 32'h0, '{1'b1, 4'd6, 32'h000000AB, 1'b1, 4'd9, 32'h5004});

        // Reset while a transfer waits on ack.
        @(negedge clk);
        mem_valid_in = 1'b1; load_store = 1'b1; byte_word = 1'b0; pre_post = 1'b1;
        up_down = 1'b1; write_back = 1'b1; base_data = 32'h6000; offset_data = 32'h4;
        rd = 4'd1; rn = 4'd2;
        @(posedge clk);
        #1;
        mem_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, dm_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_pulse", {31'd0, wb_valid | base_wb_valid}, 32'd0);
            chk("post_rst_req", {31'd0, dm_req}, 32'd0);
        end
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage controller that consumes the EX pipeline register outputs and executes ARM single-data-transfer loads and stores (LDR/STR/LDRB/STRB). It computes the effective address with pre/post indexing and up/down offset, runs a request/acknowledge transaction on the data-memory port, and returns load data and base-register writeback to the WB stage. While a transfer is in flight it stalls the upstream pipeline.

## Interface
- No parameters; all widths are fixed at 32-bit data/address and 4-bit register index.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- mem_valid_in  in  1  current EX-register slot holds a load/store
- load_store  in  1  1 = load, 0 = store
- byte_word  in  1  1 = byte, 0 = word
- pre_post  in  1  1 = pre-index, 0 = post-index
- up_down  in  1  1 = base + offset, 0 = base − offset
- write_back  in  1  base writeback requested (W bit)
- base_data  in  32  Rn value
- offset_data  in  32  resolved offset
- store_data  in  32  Rd value for stores
- rd  in  4  transfer register
- rn  in  4  base register
- stall  out  1  hold EX register and earlier stages
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_addr  out  32  word-aligned address
- dm_wdata  out  32  write data
- dm_be  out  4  byte enables
- dm_rdata  in  32  read data, valid when dm_ack = 1
- dm_ack  in  1  transaction complete
- wb_valid  out  1  one-cycle pulse: write wb_data to wb_rd
- wb_rd  out  4  load destination
- wb_data  out  32  load result
- base_wb_valid  out  1  one-cycle pulse: write base_wb_data to base_wb_rn
- base_wb_rn  out  4  base register index
- base_wb_data  out  32  updated base

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if mem_valid_in = 1, capture all inputs, compute eff = up_down ? base + offset : base − offset (mod 2^32), addr = pre_post ? eff : base_data; go to ACCESS. Otherwise remain in IDLE with no outputs.
- ACCESS: dm_req = 1 and all dm_* outputs are held stable until dm_ack = 1 is sampled. On that edge, capture dm_rdata and go to RESP.
- RESP: wb_valid and base_wb_valid pulse for this cycle only; go to IDLE.
- dm_addr = {addr[31:2], 2'b00} in all cases; addr[1:0] selects the byte lane.
- Word access: dm_be = 4'hF; dm_wdata = store_data; load data = dm_rdata.
- Byte access: dm_be = 4'b0001 << addr[1:0]; dm_wdata = {4{store_data[7:0]}}; load data = selected lane, zero-extended.
- wb_valid = load_store, with wb_rd = rd.
- base_wb_valid = write_back OR NOT pre_post, with base_wb_rn = rn and base_wb_data = eff.
- If load and rd == rn, the base writeback is suppressed and the load result wins.
- stall = (IDLE AND mem_valid_in) OR ACCESS. stall is 0 in RESP, so upstream advances at the end of RESP.
- dm_ack is ignored outside ACCESS.

## Timing
- Reset values, applied asynchronously: state IDLE; dm_req, dm_we, wb_valid, base_wb_valid = 0; dm_addr, dm_wdata, wb_data, base_wb_data = 0; dm_be, wb_rd, base_wb_rn = 0.
- stall is combinational and is 0 under reset.
- Minimum latency is 3 cycles from acceptance to the next acceptance:
  - edge 0: accept;
  - cycle 1: dm_req = 1 (dm_ack may be 1 in this cycle);
  - cycle 2: RESP pulses;
  - edge 3: next instruction may be accepted.
- Each additional cycle with dm_ack = 0 adds one cycle.
- Reset asserted during ACCESS: dm_req drops immediately. No writeback pulse follows, and no memory transaction is considered complete.
- Back-to-back memory ops are separated by exactly one IDLE cycle.

## Test plan
- Word load, pre-index, up, W = 1: base 0x1000, offset 0x8, rd = 2, rn = 3, dm_ack in the first request cycle.
  - Expect dm_addr = 0x1008 and dm_be = F.
  - Next cycle: wb_valid with wb_data = dm_rdata (0xDEADBEEF); base_wb_data = 0x1008, rn = 3.
- Byte store, post-index, down: base 0x2003, offset 0x4, store_data 0x000000A5.
  - Expect dm_addr = 0x2000, dm_be = 4'b1000, dm_wdata = 0xA5A5A5A5, wb_valid = 0.
  - base_wb_data = 0x1FFF.
- Byte load from lane 2, dm_rdata = 0x11CC2233, with 3 wait cycles.
  - Expect stall high for 4 cycles after acceptance, dm_* stable throughout, then wb_data = 0x000000CC.
- Address wrap: base 0xFFFFFFFC, offset 8, up, pre.
  - Expect dm_addr = 0x00000004.
- Load with rd == rn = 5 and W = 1.
  - Expect wb_valid = 1 with the loaded value and base_wb_valid = 0.
- Reset pulse low while dm_req = 1 and dm_ack = 0.
  - Expect dm_req = 0 and stall = 0 immediately, and no wb_valid or base_wb_valid after release.
